crc_byteen_check: RTL and testbench
===================================

CRC_BYTEEN_CHECK -- requirements
Module: crc_byteen_check

Interface
REQ-001 The block SHALL take parameter DWIDTH, default 512, bus width in bits, a multiple of 8.
REQ-002 The block SHALL take parameter CRC_WIDTH, default 32, CRC width in bits, a multiple of 8.
REQ-003 The block SHALL take parameter PIPE_LVL, default 2, pipeline level forwarded to the CRC core.
REQ-004 The block SHALL take parameters CRC_POLY, INIT, XOR_OUT, REFIN and REFOUT, defaults 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, with the same meaning as in crc_byteEn_top.
REQ-005 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-006 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- din  in  DWIDTH  frame data, first byte in the MSBs
- byteEn  in  DWIDTH/8  byte valid mask, bit DWIDTH/8-1 maps to the MSB byte
- dlast  in  1  last flit of frame
- flitEn  in  1  flit valid
- chk_vld  out  1  one-cycle result strobe
- chk_ok  out  1  frame passed all checks
- chk_short  out  1  frame shorter than CRC_WIDTH/8+1 bytes
- chk_malformed  out  1  illegal byteEn pattern seen in frame
- chk_len  out  16  frame byte count, including the trailer
- cnt_ok  out  32  good-frame counter
- cnt_bad  out  32  bad-frame counter

Function
REQ-007 The block SHALL treat the last CRC_WIDTH/8 bytes of each frame as the transmitted CRC trailer: MSB-first when REFOUT=0, LSB-first when REFOUT=1.
REQ-008 The block SHALL pass the entire frame, trailer included, through a crc_byteEn_top instance and compare crc_out against the constant RESIDUE; CRC-32 defaults give RESIDUE 32'h2144DF1C.
REQ-009 The frame FSM SHALL have two states, IDLE and IN_FRAME, and transition as follows:
- IDLE->IN_FRAME on flitEn&!dlast.
- IN_FRAME->IDLE on flitEn&dlast.
- flitEn&dlast in IDLE completes a single-flit frame and stays in IDLE.
- flitEn=0 holds the state.
REQ-010 byteEn rules: a non-last flit SHALL be all ones; a last flit SHALL be a non-zero contiguous run starting at the MSB. Any violation SHALL set a per-frame malformed flag.
REQ-011 A byte counter SHALL add popcount(byteEn) on each accepted flit, saturate at 16'hFFFF, and clear at frame end.
REQ-012 On frame end, the flags {malformed, short, len} SHALL be pushed into a metadata FIFO of depth PIPE_LVL+4. The FIFO is popped on crc_out_vld; overflow cannot occur at one frame per cycle.
REQ-013 chk_vld SHALL assert for exactly one cycle, on the cycle after crc_out_vld.
REQ-014 chk_ok SHALL equal (crc_out==RESIDUE)&!short&!malformed. chk_short, chk_malformed and chk_len SHALL come from the popped FIFO entry.
REQ-015 Result outputs SHALL hold their values until the next chk_vld.
REQ-016 With chk_vld, cnt_ok SHALL increment when chk_ok=1 and cnt_bad SHALL increment otherwise; both counters saturate at 32'hFFFFFFFF.
REQ-017 Back-to-back frames, one per cycle with no gaps, SHALL be sustained with in-order results.

Reset
REQ-018 Asserting rst_n=0 at any time, including mid-frame, SHALL drive the FSM to IDLE and clear all outputs, counters, the byte counter and the FIFO to 0.
REQ-019 The CRC core reset SHALL be driven by ~rst_n; a frame cut off by reset SHALL produce no result.
REQ-020 After rst_n deasserts, the first accepted flit SHALL be treated as a start of frame.

Structure
REQ-021 A shared package crc_chk_pkg SHALL hold the residue function crc_residue(poly, init, xorout, refin, refout, width), the state enum, and the result-record typedef.
REQ-022 The block SHALL contain exactly one sub-module: crc_byteEn_top, named u_crc_byteEn_top.

Verification
REQ-023 The bench SHALL cover these directed scenarios with DWIDTH=64 and CRC-32 defaults:
- Frame "123456789"+26 39 F4 CB (13 bytes: flit0 byteEn FF, flit1 byteEn F8) -> chk_vld once, chk_ok=1, chk_len=13, cnt_ok=1.
- Same frame with bit 0 of byte 3 flipped -> chk_ok=0, chk_short=0, cnt_bad=1.
- 4-byte single-flit frame, byteEn F0 -> chk_short=1, chk_ok=0.
- Non-last flit with byteEn F0, then valid last flit -> chk_malformed=1, chk_ok=0.
- 16 good single-flit frames on consecutive cycles, plus random flitEn gaps -> 16 in-order chk_vld pulses, cnt_ok=16.
- rst_n pulsed low mid-frame, then one good frame -> exactly one chk_vld, chk_ok=1, cnt_ok=1.

Source files
------------

// File: rtl/crc_chk_pkg.sv
// Shared types and CRC helpers for the frame CRC checker and its CRC core.
// Widths up to 64 bits are handled by working in a 64-bit container and masking.
package crc_chk_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_e;

    // Per-frame flags carried alongside the CRC pipeline
    typedef struct packed {
        logic        malformed;
        logic        is_short;
        logic [15:0] len;
    } meta_t;

    function automatic logic [63:0] crc_mask(input int width);
        return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    endfunction

    function automatic logic [63:0] crc_reflect(input logic [63:0] v, input int width);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++)
            if (i < width) r[i] = v[width-1-i];
        return r;
    endfunction

    // One byte through an MSB-first shift register; refin feeds the byte LSB first
    function automatic logic [63:0] crc_upd_byte(input logic [63:0] crc, input logic [7:0] b,
                                                 input logic [63:0] poly, input int width,
                                                 input logic refin);
        logic [63:0] c;
        logic [7:0]  bb;
        logic        msb;
        bb = b;
        if (refin)
            for (int i = 0; i < 8; i++) bb[i] = b[7-i];
        c = crc ^ ({56'd0, bb} << (width - 8));
        for (int k = 0; k < 8; k++) begin
            msb = c[width-1];
            c   = (c << 1) & crc_mask(width);
            if (msb) c = c ^ (poly & crc_mask(width));
        end
        return c;
    endfunction

    function automatic logic [63:0] crc_finalize(input logic [63:0] crc, input logic [63:0] xorout,
                                                 input logic refout, input int width);
        return ((refout ? crc_reflect(crc, width) : crc) ^ xorout) & crc_mask(width);
    endfunction

    // Residue = CRC of any frame followed by its own trailer; the empty frame is the cheapest one
    function automatic logic [63:0] crc_residue(input logic [63:0] poly, input logic [63:0] init,
                                                input logic [63:0] xorout, input logic refin,
                                                input logic refout, input int width);
        logic [63:0] r;
        logic [63:0] fin;
        logic [7:0]  b;
        r   = init & crc_mask(width);
        fin = crc_finalize(r, xorout, refout, width);
        for (int k = 0; k < 8; k++) begin
            if (k < width / 8) begin
                b = refout ? 8'(fin >> (8 * k)) : 8'(fin >> (width - 8 - 8 * k));
                r = crc_upd_byte(r, b, poly, width, refin);
            end
        end
        return crc_finalize(r, xorout, refout, width);
    endfunction

endpackage

// File: rtl/crc_byteEn_top.sv
// Byte-enabled streaming CRC core. Enabled bytes are consumed MSB byte first;
// the finalized CRC of each frame appears PIPE_LVL cycles after its last flit.
module crc_byteEn_top import crc_chk_pkg::*; #(
    parameter int                   DWIDTH    = 512,
    parameter int                   CRC_WIDTH = 32,
    parameter int                   PIPE_LVL  = 2,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 'h04C11DB7,
    parameter logic [CRC_WIDTH-1:0] INIT      = 'hFFFFFFFF,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT   = 'hFFFFFFFF,
    parameter int                   REFIN     = 1,
    parameter int                   REFOUT    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DWIDTH-1:0]      din,
    input  logic [DWIDTH/8-1:0]    byteEn,
    input  logic                   dlast,
    input  logic                   flitEn,
    output logic [CRC_WIDTH-1:0]   crc_out,
    output logic                   crc_out_vld
);
    localparam int NB = DWIDTH / 8;

    logic                                sof;
    logic [CRC_WIDTH-1:0]                crc_q;
    logic [CRC_WIDTH-1:0]                crc_nxt;
    logic [CRC_WIDTH-1:0]                crc_fin;
    logic [PIPE_LVL-1:0]                 vld_pipe;
    logic [PIPE_LVL-1:0][CRC_WIDTH-1:0]  crc_pipe;

    // Fold every enabled byte of the flit into the running CRC
    always_comb begin
        logic [63:0] c;
        c = sof ? 64'(INIT) : 64'(crc_q);
        for (int i = 0; i < NB; i++)
            if (byteEn[NB-1-i])
                c = crc_upd_byte(c, din[DWIDTH-8-8*i +: 8], 64'(CRC_POLY), CRC_WIDTH, REFIN != 0);
        crc_nxt = c[CRC_WIDTH-1:0];
        crc_fin = CRC_WIDTH'(crc_finalize(c, 64'(XOR_OUT), REFOUT != 0, CRC_WIDTH));
    end

    // Running CRC state; the flit after a last flit restarts from INIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sof   <= 1'b1;
            crc_q <= '0;
        end else if (flitEn) begin
            sof   <= dlast;
            crc_q <= crc_nxt;
        end
    end

    // Result pipeline; reset flushes any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            crc_pipe <= '0;
        end else begin
            vld_pipe[0] <= flitEn & dlast;
            crc_pipe[0] <= crc_fin;
            for (int s = 1; s < PIPE_LVL; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                crc_pipe[s] <= crc_pipe[s-1];
            end
        end
    end

    assign crc_out     = crc_pipe[PIPE_LVL-1];
    assign crc_out_vld = vld_pipe[PIPE_LVL-1];

endmodule

// File: rtl/crc_byteen_check.sv
// Frame checker: runs each frame (trailer included) through the CRC core, checks the
// residue, byteEn shape and minimum length, and keeps good/bad frame counters.
module crc_byteen_check import crc_chk_pkg::*; #(
    parameter int                   DWIDTH    = 512,
    parameter int                   CRC_WIDTH = 32,
    parameter int                   PIPE_LVL  = 2,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 'h04C11DB7,
    parameter logic [CRC_WIDTH-1:0] INIT      = 'hFFFFFFFF,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT   = 'hFFFFFFFF,
    parameter int                   REFIN     = 1,
    parameter int                   REFOUT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DWIDTH-1:0]     din,
    input  logic [DWIDTH/8-1:0]   byteEn,
    input  logic                  dlast,
    input  logic                  flitEn,
    output logic                  chk_vld,
    output logic                  chk_ok,
    output logic                  chk_short,
    output logic                  chk_malformed,
    output logic [15:0]           chk_len,
    output logic [31:0]           cnt_ok,
    output logic [31:0]           cnt_bad
);
    localparam int NB    = DWIDTH / 8;
    localparam int DEPTH = PIPE_LVL + 4;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [CRC_WIDTH-1:0] RESIDUE = CRC_WIDTH'(crc_residue(
        64'(CRC_POLY), 64'(INIT), 64'(XOR_OUT), REFIN != 0, REFOUT != 0, CRC_WIDTH));
    localparam logic [15:0] MIN_LEN = 16'(CRC_WIDTH / 8 + 1);

    state_e               state;
    logic [15:0]          len_acc;
    logic                 mal_acc;
    logic [15:0]          pc;
    logic [15:0]          len_now;
    logic                 mal_now;
    logic                 flit_bad;
    logic [NB-1:0]        be_inv;
    logic [16:0]          len_sum;

    logic [CRC_WIDTH-1:0] crc_out;
    logic                 crc_out_vld;

    meta_t                fifo_mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          count;
    logic                 push;
    logic                 pop;
    meta_t                head;
    logic                 ok_now;

    crc_byteEn_top #(
        .DWIDTH    (DWIDTH),
        .CRC_WIDTH (CRC_WIDTH),
        .PIPE_LVL  (PIPE_LVL),
        .CRC_POLY  (CRC_POLY),
        .INIT      (INIT),
        .XOR_OUT   (XOR_OUT),
        .REFIN     (REFIN),
        .REFOUT    (REFOUT)
    ) u_crc_byteEn_top (
        .clk         (clk),
        .rst         (~rst_n),
        .din         (din),
        .byteEn      (byteEn),
        .dlast       (dlast),
        .flitEn      (flitEn),
        .crc_out     (crc_out),
        .crc_out_vld (crc_out_vld)
    );

    // Per-flit byte count and shape check; a last flit must be 1..10..0 from the MSB
    always_comb begin
        pc = '0;
        for (int i = 0; i < NB; i++) pc = pc + 16'(byteEn[i]);
        be_inv   = ~byteEn;
        flit_bad = dlast ? ((byteEn == '0) || ((be_inv & (be_inv + NB'(1))) != '0))
                         : (byteEn != '1);
        len_sum  = {1'b0, (state == IDLE) ? 16'd0 : len_acc} + {1'b0, pc};
        len_now  = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        mal_now  = ((state == IDLE) ? 1'b0 : mal_acc) | flit_bad;
    end

    // Frame FSM and accumulators, cleared at frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            len_acc <= '0;
            mal_acc <= 1'b0;
        end else if (flitEn) begin
            if (dlast) begin
                state   <= IDLE;
                len_acc <= '0;
                mal_acc <= 1'b0;
            end else begin
                state   <= IN_FRAME;
                len_acc <= len_now;
                mal_acc <= mal_now;
            end
        end
    end

    assign push = flitEn & dlast;
    assign pop  = crc_out_vld & (count != '0);
    assign head = fifo_mem[rd_ptr];

    // Metadata FIFO, one entry per frame, matched to CRC results in order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{malformed: mal_now, is_short: (len_now < MIN_LEN), len: len_now};
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign ok_now = (crc_out == RESIDUE) & ~head.is_short & ~head.malformed;

    // Result registers hold between strobes; counters saturate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_vld       <= 1'b0;
            chk_ok        <= 1'b0;
            chk_short     <= 1'b0;
            chk_malformed <= 1'b0;
            chk_len       <= '0;
            cnt_ok        <= '0;
            cnt_bad       <= '0;
        end else begin
            chk_vld <= crc_out_vld;
            if (crc_out_vld) begin
                chk_ok        <= ok_now;
                chk_short     <= head.is_short;
                chk_malformed <= head.malformed;
                chk_len       <= head.len;
                if (ok_now) begin
                    if (cnt_ok != 32'hFFFFFFFF) cnt_ok <= cnt_ok + 32'd1;
                end else begin
                    if (cnt_bad != 32'hFFFFFFFF) cnt_bad <= cnt_bad + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_crc_byteen_check.sv
// Directed bench for crc_byteen_check at DWIDTH=64 with CRC-32 defaults.
module tb_crc_byteen_check;
    localparam int DW = 64;
    localparam int NB = DW / 8;

    // "12345678" / "9"+CRC32("123456789") LSB first
    localparam logic [63:0] F0_D  = 64'h3132333435363738;
    localparam logic [63:0] F1_D  = 64'h392639F4CB000000;
    localparam logic [63:0] F0_BAD = 64'h3132333535363738;
    // "a"+CRC32("a") = E8B7BE43, "abc"+CRC32("abc") = 352441C2
    localparam logic [63:0] A_D   = 64'h6143BEB7E8000000;
    localparam logic [63:0] ABC_D = 64'h616263C241243500;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DW-1:0]   din = '0;
    logic [NB-1:0]   byteEn = '0;
    logic            dlast = 1'b0;
    logic            flitEn = 1'b0;
    logic            chk_vld, chk_ok, chk_short, chk_malformed;
    logic [15:0]     chk_len;
    logic [31:0]     cnt_ok, cnt_bad;

    int n_checks = 0;
    int n_pass   = 0;
    int base;

    logic        r_ok[$];
    logic        r_short[$];
    logic        r_mal[$];
    logic [15:0] r_len[$];

    crc_byteen_check #(.DWIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .byteEn(byteEn), .dlast(dlast), .flitEn(flitEn),
        .chk_vld(chk_vld), .chk_ok(chk_ok), .chk_short(chk_short), .chk_malformed(chk_malformed),
        .chk_len(chk_len), .cnt_ok(cnt_ok), .cnt_bad(cnt_bad)
    );

    always #5 clk = ~clk;

    // Record every result strobe, sampled mid-cycle
    always @(negedge clk) begin
        if (chk_vld) begin
            r_ok.push_back(chk_ok);
            r_short.push_back(chk_short);
            r_mal.push_back(chk_malformed);
            r_len.push_back(chk_len);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic flit(input logic [63:0] d, input logic [7:0] be, input logic last);
        @(negedge clk);
        din = d; byteEn = be; dlast = last; flitEn = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            flitEn = 1'b0; dlast = 1'b0; byteEn = '0;
        end
    endtask

    task automatic wait_res(input int target, input string tag);
        int t = 0;
        while (r_ok.size() < target && t < 100) begin
            @(posedge clk);
            t++;
        end
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk({tag, "_count"}, 64'(r_ok.size()), 64'(target));
    endtask

    task automatic good13();
        flit(F0_D, 8'hFF, 1'b0);
        flit(F1_D, 8'hF8, 1'b1);
        idle(1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_vld", 64'(chk_vld), 64'd0);
        chk("rst_ok", 64'(chk_ok), 64'd0);
        chk("rst_len", 64'(chk_len), 64'd0);
        chk("rst_cnt_ok", 64'(cnt_ok), 64'd0);
        chk("rst_cnt_bad", 64'(cnt_bad), 64'd0);
        rst_n = 1'b1;

        // Good 13-byte frame
        base = r_ok.size();
        good13();
        wait_res(base + 1, "good");
        chk("good_ok", 64'(r_ok[base]), 64'd1);
        chk("good_len", 64'(r_len[base]), 64'd13);
        chk("good_short", 64'(r_short[base]), 64'd0);
        chk("good_mal", 64'(r_mal[base]), 64'd0);
        chk("good_cnt_ok", 64'(cnt_ok), 64'd1);
        chk("good_cnt_bad", 64'(cnt_bad), 64'd0);
        chk("hold_ok", 64'(chk_ok), 64'd1);
        chk("hold_len", 64'(chk_len), 64'd13);
        chk("hold_vld_low", 64'(chk_vld), 64'd0);

        // Corrupted payload
        base = r_ok.size();
        flit(F0_BAD, 8'hFF, 1'b0);
        flit(F1_D, 8'hF8, 1'b1);
        idle(1);
        wait_res(base + 1, "crcerr");
        chk("crcerr_ok", 64'(r_ok[base]), 64'd0);
        chk("crcerr_short", 64'(r_short[base]), 64'd0);
        chk("crcerr_cnt_bad", 64'(cnt_bad), 64'd1);
        chk("crcerr_cnt_ok", 64'(cnt_ok), 64'd1);

        // Short 4-byte frame
        base = r_ok.size();
        flit(64'hDEADBEEF00000000, 8'hF0, 1'b1);
        idle(1);
        wait_res(base + 1, "short");
        chk("short_flag", 64'(r_short[base]), 64'd1);
        chk("short_ok", 64'(r_ok[base]), 64'd0);
        chk("short_len", 64'(r_len[base]), 64'd4);
        chk("short_cnt_bad", 64'(cnt_bad), 64'd2);

        // Partial non-last flit
        base = r_ok.size();
        flit(F0_D, 8'hF0, 1'b0);
        flit(F1_D, 8'hF8, 1'b1);
        idle(1);
        wait_res(base + 1, "malmid");
        chk("malmid_flag", 64'(r_mal[base]), 64'd1);
        chk("malmid_ok", 64'(r_ok[base]), 64'd0);
        chk("malmid_len", 64'(r_len[base]), 64'd9);

        // Non-contiguous last-flit mask
        base = r_ok.size();
        flit(ABC_D, 8'hFD, 1'b1);
        idle(1);
        wait_res(base + 1, "malgap");
        chk("malgap_flag", 64'(r_mal[base]), 64'd1);
        chk("malgap_ok", 64'(r_ok[base]), 64'd0);
        chk("malgap_len", 64'(r_len[base]), 64'd7);
        chk("malgap_cnt_bad", 64'(cnt_bad), 64'd4);

        // 16 single-flit frames: back-to-back then with gaps
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        base = r_ok.size();
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) flit(A_D, 8'hF8, 1'b1);
            else            flit(ABC_D, 8'hFE, 1'b1);
            if (k >= 8) idle(int'($urandom_range(0, 2)));
        end
        idle(1);
        wait_res(base + 16, "burst");
        for (int k = 0; k < 16; k++) begin
            if (base + k < r_ok.size()) begin
                chk($sformatf("burst_ok%0d", k), 64'(r_ok[base+k]), 64'd1);
                chk($sformatf("burst_len%0d", k), 64'(r_len[base+k]), (k % 2 == 0) ? 64'd5 : 64'd7);
            end
        end
        chk("burst_cnt_ok", 64'(cnt_ok), 64'd16);
        chk("burst_cnt_bad", 64'(cnt_bad), 64'd0);

        // Reset mid-frame, then one good frame
        base = r_ok.size();
        flit(F0_D, 8'hFF, 1'b0);
        @(negedge clk);
        flitEn = 1'b0; dlast = 1'b0; rst_n = 1'b0;
        #1;
        chk("midrst_cnt_ok", 64'(cnt_ok), 64'd0);
        chk("midrst_len", 64'(chk_len), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        good13();
        wait_res(base + 1, "midrst");
        if (r_ok.size() > base) chk("midrst_ok", 64'(r_ok[base]), 64'd1);
        chk("midrst_cnt_ok", 64'(cnt_ok), 64'd1);
        chk("midrst_cnt_bad", 64'(cnt_bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
